// File: rtl/fc_layer_engine.sv
// fc_layer_engine: sequential fully-connected layer, one MAC per cycle.
// Build option FC_ENGINE_RELU_EN clamps negative results to zero.
module fc_layer_engine #(
   parameter int IN_NUM   = 64,
   parameter int OUT_NUM  = 2,
   parameter int GROUPS   = 42,
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int ACC_W    = 24,
   parameter int SHIFT    = 10,
   localparam int DA_W = (GROUPS * IN_NUM > 1) ? $clog2(GROUPS * IN_NUM) : 1,
   localparam int WA_W = (OUT_NUM * IN_NUM > 1) ? $clog2(OUT_NUM * IN_NUM) : 1,
   localparam int BA_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1,
   localparam int GW   = (GROUPS > 1) ? $clog2(GROUPS) : 1,
   localparam int IW   = (IN_NUM > 1) ? $clog2(IN_NUM) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       data_rd_en,
   output logic [DA_W-1:0]            data_addr,
   input  logic signed [DATA_W-1:0]   data_rd,
   output logic                       w_rd_en,
   output logic [WA_W-1:0]            w_addr,
   input  logic signed [WEIGHT_W-1:0] w_rd,
   output logic                       b_rd_en,
   output logic [BA_W-1:0]            b_addr,
   input  logic signed [ACC_W-1:0]    b_rd,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [DATA_W-1:0]   out_data,
   output logic [GW-1:0]              out_group,
   output logic [BA_W-1:0]            out_idx
);

   typedef enum logic [2:0] {
      IDLE, BIAS, MAC, DRAIN, OUT, DONE
   } state_t;

   localparam int PW = DATA_W + WEIGHT_W;
   localparam logic signed [ACC_W-1:0] SMAX =
      ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

   state_t                  state_q, state_d;
   logic [GW-1:0]           g_q, g_d;
   logic [BA_W-1:0]         o_q, o_d;
   logic [IW-1:0]           i_q, i_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  prod_x;
   logic signed [ACC_W-1:0]  acc_sh;
   logic signed [DATA_W-1:0] res;
   logic [DA_W-1:0]          da;
   logic [WA_W-1:0]          wa;
   logic                     last_i, last_o, last_g;

   assign prod   = data_rd * w_rd;
   assign prod_x = ACC_W'(prod);
   assign acc_sh = acc_q >>> SHIFT;

   assign da = DA_W'(32'(g_q) * 32'(IN_NUM) + 32'(i_q));
   assign wa = WA_W'(32'(o_q) * 32'(IN_NUM) + 32'(i_q));

   assign last_i = (i_q == IW'(IN_NUM - 1));
   assign last_o = (o_q == BA_W'(OUT_NUM - 1));
   assign last_g = (g_q == GW'(GROUPS - 1));

   always_comb begin
      if (acc_sh > SMAX) begin
         res = SMAX[DATA_W-1:0];
      end else if (acc_sh < SMIN) begin
         res = SMIN[DATA_W-1:0];
      end else begin
         res = acc_sh[DATA_W-1:0];
      end
`ifdef FC_ENGINE_RELU_EN
      if (res[DATA_W-1]) begin
         res = '0;
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      o_d        = o_q;
      i_d        = i_q;
      acc_d      = acc_q;
      busy       = (state_q != IDLE);
      done       = 1'b0;
      data_rd_en = 1'b0;
      w_rd_en    = 1'b0;
      b_rd_en    = 1'b0;
      data_addr  = '0;
      w_addr     = '0;
      b_addr     = '0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_group  = '0;
      out_idx    = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               g_d     = '0;
               o_d     = '0;
               i_d     = '0;
               state_d = BIAS;
            end
         end
         BIAS: begin
            b_rd_en = 1'b1;
            b_addr  = o_q;
            i_d     = '0;
            state_d = MAC;
         end
         MAC: begin
            data_rd_en = 1'b1;
            w_rd_en    = 1'b1;
            data_addr  = da;
            w_addr     = wa;
            // product of request i-1 lands while request i issues
            if (i_q == '0) begin
               acc_d = b_rd;
            end else begin
               acc_d = acc_q + prod_x;
            end
            if (last_i) begin
               i_d     = '0;
               state_d = DRAIN;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         DRAIN: begin
            acc_d   = acc_q + prod_x;
            state_d = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            out_data  = res;
            out_group = g_q;
            out_idx   = o_q;
            if (out_ready) begin
               if (last_o) begin
                  o_d = '0;
                  if (last_g) begin
                     state_d = DONE;
                  end else begin
                     g_d     = g_q + 1'b1;
                     state_d = BIAS;
                  end
               end else begin
                  o_d     = o_q + 1'b1;
                  state_d = BIAS;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         g_q     <= '0;
         o_q     <= '0;
         i_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         o_q     <= o_d;
         i_q     <= i_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: table-driven runs with a result scoreboard,
// plus stall, abort, busy-start and degenerate-size sequences.
module tb_fc_layer_engine;

   localparam int IN_NUM  = 4;
   localparam int OUT_NUM = 2;
   localparam int GROUPS  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic out_ready = 1'b1;
   logic busy, done, data_rd_en, w_rd_en, b_rd_en, out_valid;
   logic [2:0] data_addr, w_addr;
   logic [0:0] b_addr, out_group, out_idx;
   logic signed [7:0] data_rd, w_rd, out_data;
   logic signed [23:0] b_rd;

   logic d_start = 1'b0;
   logic d_out_ready = 1'b1;
   logic d_busy, d_done, d_data_rd_en, d_w_rd_en, d_b_rd_en, d_out_valid;
   logic [0:0] d_data_addr, d_w_addr, d_b_addr, d_out_group, d_out_idx;
   logic signed [7:0] d_data_rd, d_w_rd, d_out_data;
   logic signed [23:0] d_b_rd;

   logic signed [7:0]  dmem [8];
   logic signed [7:0]  wmem [8];
   logic signed [23:0] bmem [2];
   logic signed [7:0]  d_dmem [2];
   logic signed [7:0]  d_wmem [2];
   logic signed [23:0] d_bmem [2];

   always #5 clk = ~clk;

   fc_layer_engine #(
      .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .GROUPS(GROUPS),
      .DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .SHIFT(0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done),
      .data_rd_en(data_rd_en), .data_addr(data_addr), .data_rd(data_rd),
      .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd(w_rd),
      .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rd(b_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_group(out_group), .out_idx(out_idx)
   );

   fc_layer_engine #(
      .IN_NUM(1), .OUT_NUM(1), .GROUPS(1),
      .DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .SHIFT(2)
   ) u_deg (
      .clk(clk), .rst_n(rst_n), .start(d_start),
      .busy(d_busy), .done(d_done),
      .data_rd_en(d_data_rd_en), .data_addr(d_data_addr),
      .data_rd(d_data_rd),
      .w_rd_en(d_w_rd_en), .w_addr(d_w_addr), .w_rd(d_w_rd),
      .b_rd_en(d_b_rd_en), .b_addr(d_b_addr), .b_rd(d_b_rd),
      .out_valid(d_out_valid), .out_ready(d_out_ready),
      .out_data(d_out_data),
      .out_group(d_out_group), .out_idx(d_out_idx)
   );

   always @(posedge clk) begin
      if (data_rd_en) data_rd <= dmem[data_addr];
      if (w_rd_en) w_rd <= wmem[w_addr];
      if (b_rd_en) b_rd <= bmem[b_addr];
      if (d_data_rd_en) d_data_rd <= d_dmem[d_data_addr];
      if (d_w_rd_en) d_w_rd <= d_wmem[d_w_addr];
      if (d_b_rd_en) d_b_rd <= d_bmem[d_b_addr];
   end

   typedef struct {
      int g;
      int o;
      int v;
   } exp_t;

   typedef struct {
      int d;
      int w;
      int b;
      int exp;
   } vec_t;

   exp_t sb [$];
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_hs = -1;
   int n_done = 0;
   bit gap_chk = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int relu(input int v);
`ifdef FC_ENGINE_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   function automatic int sat8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int model(input int g, input int o, input int sh);
      logic signed [23:0] a;
      int p;
      a = bmem[o];
      for (int i = 0; i < IN_NUM; i++) begin
         p = int'(dmem[g * IN_NUM + i]) * int'(wmem[o * IN_NUM + i]);
         a = a + 24'(p);
      end
      return relu(sat8(int'(a) >>> sh));
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (start && !busy) last_hs = -1;
            if (out_valid && (data_rd_en || w_rd_en || b_rd_en))
               chk("rd_en_during_out", 1, 0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("out_data", int'(out_data), e.v);
                  chk("out_group", int'(out_group), e.g);
                  chk("out_idx", int'(out_idx), e.o);
               end
               if (gap_chk && last_hs >= 0)
                  chk("result_gap", cyc - last_hs, IN_NUM + 3);
               last_hs = cyc;
            end
            if (done) begin
               n_done++;
               chk("done_after_last", cyc - last_hs, 1);
            end
         end
      end
   end

   task automatic fill(input vec_t v);
      for (int i = 0; i < 8; i++) begin
         dmem[i] = 8'(v.d);
         wmem[i] = 8'(v.w);
      end
      bmem[0] = 24'(v.b);
      bmem[1] = 24'(v.b);
   endtask

   task automatic push_uniform(input int v);
      exp_t e;
      for (int g = 0; g < GROUPS; g++) begin
         for (int o = 0; o < OUT_NUM; o++) begin
            e.g = g;
            e.o = o;
            e.v = relu(v);
            sb.push_back(e);
         end
      end
   endtask

   task automatic push_model();
      exp_t e;
      for (int g = 0; g < GROUPS; g++) begin
         for (int o = 0; o < OUT_NUM; o++) begin
            e.g = g;
            e.o = o;
            e.v = model(g, o, 0);
            sb.push_back(e);
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit poke);
      int base;
      int k;
      base = n_done;
      k = 0;
      while (n_done == base && k < budget) begin
         @(posedge clk);
         #1 start = poke && (k == 3 || k == 12 || k == 30);
         k++;
      end
      start = 1'b0;
      chk("done_seen", n_done - base, 1);
      chk("idle_after_done", int'(busy), 0);
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   vec_t tbl [7];
   vec_t dtbl [2];

   initial begin : main
      int k;
      int held;
      int base;

      tbl[0] = '{1, 2, 3, 11};
      tbl[1] = '{100, 100, 3, 127};
      tbl[2] = '{100, -100, 3, -128};
      tbl[3] = '{-1, 1, 0, -4};
      tbl[4] = '{5, -3, 70, 10};
      tbl[5] = '{0, 0, -7, -7};
      tbl[6] = '{10, 10, 8388600, -128};
      dtbl[0] = '{1, -4, -1, -2};
      dtbl[1] = '{1, 0, 1000, 127};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_rd_en", int'(data_rd_en | w_rd_en | b_rd_en), 0);
      chk("rst_deg_busy", int'(d_busy), 0);
      rst_n = 1'b1;

      for (int t = 0; t < 7; t++) begin
         fill(tbl[t]);
         push_uniform(tbl[t].exp);
         pulse_start();
         wait_done(200, t == 0);
      end

      for (int i = 0; i < 8; i++) begin
         dmem[i] = 8'($urandom_range(0, 255));
         wmem[i] = 8'($urandom_range(0, 255));
      end
      for (int o = 0; o < 2; o++)
         bmem[o] = 24'(int'($urandom_range(0, 4000)) - 2000);
      push_model();
      pulse_start();
      wait_done(200, 1'b1);

      gap_chk = 1'b0;
      fill(tbl[4]);
      push_uniform(tbl[4].exp);
      out_ready = 1'b0;
      pulse_start();
      k = 0;
      while (!out_valid && k < 50) begin
         @(posedge clk);
         #1 k++;
      end
      chk("stall_reached_out", int'(out_valid), 1);
      held = int'(out_data);
      repeat (20) begin
         @(posedge clk);
         #1;
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_data", int'(out_data), held);
         chk("stall_rd_en", int'(data_rd_en | w_rd_en | b_rd_en), 0);
      end
      out_ready = 1'b1;
      wait_done(200, 1'b0);
      gap_chk = 1'b1;

      fill(tbl[0]);
      push_uniform(tbl[0].exp);
      pulse_start();
      k = 0;
      while (!(data_rd_en && data_addr >= 3'd4) && k < 100) begin
         @(posedge clk);
         #1 k++;
      end
      chk("abort_reached_g1_mac", int'(data_rd_en), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_rd_en", int'(data_rd_en), 0);
      base = n_done;
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", n_done - base, 0);
      chk("abort_idle", int'(busy), 0);
      push_uniform(tbl[0].exp);
      pulse_start();
      wait_done(200, 1'b0);

      for (int t = 0; t < 2; t++) begin
         d_dmem[0] = 8'(dtbl[t].d);
         d_wmem[0] = 8'(dtbl[t].w);
         d_bmem[0] = 24'(dtbl[t].b);
         @(posedge clk);
         #1 d_start = 1'b1;
         @(posedge clk);
         #1 d_start = 1'b0;
         k = 0;
         while (!d_out_valid && k < 20) begin
            @(posedge clk);
            #1 k++;
         end
         chk("deg_valid", int'(d_out_valid), 1);
         chk("deg_data", int'(d_out_data), relu(dtbl[t].exp));
         chk("deg_tag", int'(d_out_group) + int'(d_out_idx), 0);
         @(posedge clk);
         #1;
         chk("deg_done", int'(d_done), 1);
         @(posedge clk);
         #1;
         chk("deg_idle", int'(d_busy), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
